wb_req_master: RTL and testbench

WB_REQ_MASTER -- requirements
Module: wb_req_master

---
 rtl/wb_req_master.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_req_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_req_master.sv
// Purpose : buffers read/write commands and issues them as single classic Wishbone cycles, one at a time.
// Latency : a command pushed into an empty idle block raises wb_stb_i one cycle after the push edge.
// Backpress: cmd_ready drops when the FIFO is full; the FSM stalls in RESP until rsp_ready, while the FIFO keeps filling.
//
// Ports   : sys_clk/RESET (sync, active-high); sdr_init_done gates new transactions;
//           cmd_* valid/ready command input; rsp_* valid/ready completion output;
//           wb_*_i master outputs and wb_ack_o/wb_dat_o slave inputs toward the SDRAM controller.
// Option  : define WB_TIMEOUT_EN to abort a cycle after TIMEOUT_CYC cycles without ack (rsp_err = 1).
module wb_req_master #(
    parameter int dw          = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              sys_clk,
    input  logic              RESET,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [25:0]       cmd_addr,
    input  logic [dw-1:0]     cmd_wdata,
    input  logic [dw/8-1:0]   cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic              rsp_err,
    output logic [dw-1:0]     rsp_rdata,
    output logic              wb_stb_i,
    output logic              wb_cyc_i,
    output logic              wb_we_i,
    output logic [25:0]       wb_addr_i,
    output logic [dw-1:0]     wb_dat_i,
    output logic [dw/8-1:0]   wb_sel_i,
    output logic [2:0]        wb_cti_i,
    input  logic              wb_ack_o,
    input  logic [dw-1:0]     wb_dat_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              we;
        logic [25:0]       addr;
        logic [dw-1:0]     wdata;
        logic [dw/8-1:0]   sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    cmd_t             head;
    logic             push, pop;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q, state_d;

    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [25:0]      addr_q, addr_d;
    logic [dw-1:0]    dat_q, dat_d;
    logic [dw/8-1:0]  sel_q, sel_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_we_q, rsp_we_d;
    logic [dw-1:0]    rsp_rdata_q, rsp_rdata_d;

`ifdef WB_TIMEOUT_EN
    logic             rsp_err_q, rsp_err_d;
    logic [10:0]      timer_q, timer_d;
`else
    logic             unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

    assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef WB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        timer_d     = timer_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sdr_init_done && (count_q != '0)) begin
                    pop     = 1'b1;
                    state_d = ACTIVE;
                    stb_d   = 1'b1;
                    we_d    = head.we;
                    addr_d  = head.addr;
                    dat_d   = head.wdata;
                    sel_d   = head.sel;
`ifdef WB_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            ACTIVE: begin
                // Ack is checked first so a coincident timeout loses.
                if (wb_ack_o) begin
                    state_d     = RESP;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = '0;
                    dat_d       = '0;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_rdata_d = we_q ? '0 : wb_dat_o;
`ifdef WB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (timer_q == 11'(TIMEOUT_CYC - 1)) begin
                    // This is the TIMEOUT_CYC-th ackless cycle: abort now.
                    state_d     = RESP;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = '0;
                    dat_d       = '0;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    timer_d     = timer_q + 11'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_we_d    = 1'b0;
                    rsp_rdata_d = '0;
`ifdef WB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Depth is a power of two, so pointer wrap is natural overflow.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (RESET) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            timer_q     <= timer_d;
`endif
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge sys_clk) begin
        if (push && !RESET) begin
            fifo_mem[wr_ptr_q] <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata, sel: cmd_sel};
        end
    end

    assign wb_stb_i  = stb_q;
    assign wb_cyc_i  = stb_q;
    assign wb_we_i   = we_q;
    assign wb_addr_i = addr_q;
    assign wb_dat_i  = dat_q;
    assign wb_sel_i  = sel_q;
    assign wb_cti_i  = 3'b000;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef WB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_req_master.sv
// Purpose : checks wb_req_master against a queue-based model of the command stream.
// Latency : samples on negedges, drives inputs on negedges.
// Backpress: exercises full FIFO, stalled responses, init gating and mid-cycle reset.
module tb_wb_req_master;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef WB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1023;
`endif

    logic          sys_clk;
    logic          RESET;
    logic          sdr_init_done;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [25:0]   cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          wb_stb_i, wb_cyc_i, wb_we_i;
    logic [25:0]   wb_addr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [2:0]    wb_cti_i;
    logic          wb_ack_o;
    logic [DW-1:0] wb_dat_o;

    typedef struct packed {
        logic          we;
        logic [25:0]   addr;
        logic [DW-1:0] wdata;
        logic [3:0]    sel;
    } tcmd_t;

    tcmd_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    wb_req_master #(.dw(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .RESET(RESET), .sdr_init_done(sdr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cti_i(wb_cti_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one command for one cycle; the model records it only if accepted.
    task automatic push_cmd(input logic we, input logic [25:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input bit check_rdy, input bit exp_rdy);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_sel   = s;
        if (check_rdy) chk("cmd_ready", cmd_ready, exp_rdy);
        if (cmd_ready) exp_q.push_back('{we, a, d, s});
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    // Serve one Wishbone cycle: ack on the (ack_dly+1)-th strobe cycle, then stall the response rdy_dly cycles.
    task automatic run_txn(input int ack_dly, input int rdy_dly, input logic [DW-1:0] rd);
        int            n = 0;
        int            k = 0;
        tcmd_t         e;
        logic          rwe;
        logic [DW-1:0] rdat;
        while (!wb_stb_i && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (!wb_stb_i) begin
            chk("stb_wait", wb_stb_i, 1'b1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("stb_unexpected", wb_stb_i, 1'b0);
            return;
        end
        e = exp_q.pop_front();
        chk("cyc", wb_cyc_i, 1'b1);
        chk("we", wb_we_i, e.we);
        chk("addr", wb_addr_i, e.addr);
        chk("sel", wb_sel_i, e.sel);
        chk("cti", wb_cti_i, 3'b000);
        if (e.we) chk("dat", wb_dat_i, e.wdata);
        while (wb_stb_i && k < ack_dly + 10) begin
            k++;
            if (k == ack_dly + 1) begin
                wb_ack_o = 1'b1;
                wb_dat_o = rd;
            end else begin
                wb_ack_o = 1'b0;
                wb_dat_o = $urandom;
            end
            @(negedge sys_clk);
            wb_ack_o = 1'b0;
            if (wb_stb_i)
                chk("hold", {wb_cyc_i, wb_we_i, wb_addr_i, wb_sel_i}, {1'b1, e.we, e.addr, e.sel});
        end
        chk("stb_len", k, ack_dly + 1);
        chk("bus_idle", {wb_cyc_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i}, 64'h0);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_we", rsp_we, e.we);
        chk("rsp_err", rsp_err, 1'b0);
        if (!e.we) chk("rsp_rdata", rsp_rdata, rd);
        rwe  = e.we;
        rdat = e.we ? rsp_rdata : rd;
        for (int i = 0; i < rdy_dly; i++) begin
            rsp_ready = 1'b0;
            wb_ack_o  = 1'($urandom_range(0, 1));   // stray acks must be ignored
            wb_dat_o  = $urandom;
            @(negedge sys_clk);
            chk("rsp_hold", {rsp_valid, rsp_we, rsp_err, rsp_rdata, wb_stb_i},
                {1'b1, rwe, 1'b0, rdat, 1'b0});
        end
        wb_ack_o  = 1'b0;
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 1'b0);
        if (exp_q.size() > 0 && sdr_init_done) begin
            chk("restart_gap", wb_stb_i, 1'b0);
            @(negedge sys_clk);
            chk("restart", wb_stb_i, 1'b1);
        end
    endtask

    initial begin
        int n;
        int nb;
        RESET = 1'b1; sdr_init_done = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0; rsp_ready = 1'b0;
        wb_ack_o = 1'b0; wb_dat_o = '0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_wb", {wb_stb_i, wb_cyc_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i}, 64'h0);
        chk("rst_cti", wb_cti_i, 3'b000);
        chk("rst_rsp", {rsp_valid, rsp_we, rsp_err, rsp_rdata}, 64'h0);
        RESET = 1'b0;
        sdr_init_done = 1'b1;
        @(negedge sys_clk);

        // Single write with latency check, ack on 4th strobe cycle
        push_cmd(1'b1, 26'h004, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
        chk("lat_n", wb_stb_i, 1'b0);
        @(negedge sys_clk);
        chk("lat_n1", wb_stb_i, 1'b1);
        run_txn(3, 2, 32'h0);

        // Read returning 0xDEADBEEF
        push_cmd(1'b0, 26'h004, 32'h0, 4'hF, 1'b1, 1'b1);
        run_txn(1, 0, 32'hDEADBEEF);

        // Fill FIFO with init low, 5th command refused, then drain in order
        sdr_init_done = 1'b0;
        for (int i = 0; i < 5; i++)
            push_cmd(1'($urandom_range(0, 1)), 26'(16 + i), $urandom, 4'($urandom), 1'b1, i < 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk("gated_stb", wb_stb_i, 1'b0);
        end
        sdr_init_done = 1'b1;
        for (int i = 0; i < 4; i++)
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);

        // Long response stall
        push_cmd(1'b0, 26'h123, 32'h0, 4'h3, 1'b1, 1'b1);
        push_cmd(1'b1, 26'h124, 32'hCAFEF00D, 4'hC, 1'b1, 1'b1);
        run_txn(0, 10, 32'h55AA55AA);
        run_txn(2, 1, 32'h0);

        // No-ack behaviour
        push_cmd(1'b0, 26'h3FF, 32'h0, 4'hF, 1'b1, 1'b1);
        n = 0;
        while (!wb_stb_i && n < 20) begin @(negedge sys_clk); n++; end
        chk("to_stb_start", wb_stb_i, 1'b1);
        void'(exp_q.pop_front());
        n = 0;
`ifdef WB_TIMEOUT_EN
        while (wb_stb_i && n < 100) begin @(negedge sys_clk); n++; end
        chk("to_len", n, TO);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
`else
        while (wb_stb_i && n < 2000) begin @(negedge sys_clk); n++; end
        chk("no_to_len", n, 2000);
        chk("no_to_stb", wb_stb_i, 1'b1);
        wb_ack_o = 1'b1;
        wb_dat_o = 32'h0BADCAFE;
        @(negedge sys_clk);
        wb_ack_o = 1'b0;
        chk("no_to_rsp_valid", rsp_valid, 1'b1);
        chk("no_to_rsp_err", rsp_err, 1'b0);
        chk("no_to_rsp_rdata", rsp_rdata, 32'h0BADCAFE);
`endif
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        chk("to_rsp_done", rsp_valid, 1'b0);

        // Reset in 2nd ACTIVE cycle with 2 commands queued
        sdr_init_done = 1'b0;
        for (int i = 0; i < 3; i++)
            push_cmd(1'b1, 26'(32 + i), $urandom, 4'hF, 1'b1, 1'b1);
        sdr_init_done = 1'b1;
        n = 0;
        while (!wb_stb_i && n < 20) begin @(negedge sys_clk); n++; end
        @(negedge sys_clk);
        chk("rst_act2_stb", wb_stb_i, 1'b1);
        RESET = 1'b1;
        @(negedge sys_clk);
        RESET = 1'b0;
        chk("rst_act_bus", {wb_stb_i, wb_cyc_i}, 2'b00);
        chk("rst_act_ready", cmd_ready, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            wb_ack_o = 1'($urandom_range(0, 1));
            rsp_ready = 1'b1;
            @(negedge sys_clk);
            chk("rst_discard", {rsp_valid, wb_stb_i}, 2'b00);
        end
        wb_ack_o = 1'b0;
        rsp_ready = 1'b0;

        // Randomized batches
        for (int b = 0; b < 30; b++) begin
            nb = int'($urandom_range(1, 4));
            for (int i = 0; i < nb; i++)
                push_cmd(1'($urandom_range(0, 1)), 26'($urandom), $urandom, 4'($urandom),
                         1'b1, 1'b1);
            for (int i = 0; i < nb; i++)
                run_txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
